// File: rtl/seg7_scan_ctrl.sv
// Four-digit common-anode display scanner: one slot per digit, each slot opens
// with a dark blanking interval, and all four codes are latched once per frame.
module seg7_scan_ctrl #(
    parameter int DIV   = 50000,
    parameter int BLANK = 500,
    parameter int CW    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [3:0] digit_en,
    input  logic [6:0] in0,
    input  logic [6:0] in1,
    input  logic [6:0] in2,
    input  logic [6:0] in3,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic [1:0] digit_idx,
    output logic       frame_tick
);

    typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} state_t;

    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
    localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);

    state_t      state_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]  idx_q;
    logic [1:0]  idx_d;
    logic [6:0]  seg_q;
    logic [3:0]  an_q;
    logic        frame_tick_q;
    logic [6:0]  snap_q [4];
    logic [3:0]  mask_q;

    assign idx_d = idx_q + 2'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            seg_q        <= 7'h7F;
            an_q         <= 4'hF;
            frame_tick_q <= 1'b0;
            mask_q       <= 4'h0;
            for (int i = 0; i < 4; i++) begin
                snap_q[i] <= 7'h7F;
            end
        end else begin
            frame_tick_q <= 1'b0;
            if (!enable) begin
                // Snapshot is deliberately held; re-enable always re-captures anyway.
                state_q <= S_IDLE;
                cnt_q   <= '0;
                idx_q   <= 2'd0;
                an_q    <= 4'hF;
                seg_q   <= 7'h7F;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        state_q      <= S_BLANK;
                        cnt_q        <= '0;
                        idx_q        <= 2'd0;
                        an_q         <= 4'hF;
                        seg_q        <= in0;
                        snap_q[0]    <= in0;
                        snap_q[1]    <= in1;
                        snap_q[2]    <= in2;
                        snap_q[3]    <= in3;
                        mask_q       <= digit_en;
                        frame_tick_q <= 1'b1;
                    end
                    S_BLANK: begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == BLANK_LAST) begin
                            state_q <= S_SHOW;
                            an_q    <= mask_q[idx_q] ? ~(4'b0001 << idx_q) : 4'hF;
                        end
                    end
                    S_SHOW: begin
                        if (cnt_q == DIV_LAST) begin
                            state_q <= S_BLANK;
                            cnt_q   <= '0;
                            idx_q   <= idx_d;
                            an_q    <= 4'hF;
                            // Segments switch while anodes are dark so the next digit never ghosts.
                            if (idx_q == 2'd3) begin
                                seg_q        <= in0;
                                snap_q[0]    <= in0;
                                snap_q[1]    <= in1;
                                snap_q[2]    <= in2;
                                snap_q[3]    <= in3;
                                mask_q       <= digit_en;
                                frame_tick_q <= 1'b1;
                            end else begin
                                seg_q <= snap_q[idx_d];
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign digit_idx  = idx_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: a frame-position model pushes the expected
// output of every edge to a queue, which is popped and compared after that edge.
module tb_seg7_scan_ctrl;

    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int CW    = 16;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic [1:0] idx;
        logic       ft;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] digit_en = 4'h0;
    logic [6:0] in0 = 7'h00, in1 = 7'h00, in2 = 7'h00, in3 = 7'h00;
    logic [6:0] seg;
    logic [3:0] an;
    logic [1:0] digit_idx;
    logic       frame_tick;

    seg7_scan_ctrl #(.DIV(DIV), .BLANK(BLANK), .CW(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .digit_en   (digit_en),
        .in0        (in0),
        .in1        (in1),
        .in2        (in2),
        .in3        (in3),
        .seg        (seg),
        .an         (an),
        .digit_idx  (digit_idx),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    bit         m_run = 1'b0;
    int         m_t = 0;
    logic [6:0] m_snap [4];
    logic [3:0] m_mask = 4'h0;

    task automatic check(input string tag, input exp_t e);
        exp_t obs;
        obs = {an, seg, digit_idx, frame_tick};
        n_vec++;
        assert (obs === e) else begin
            n_err++;
            $error("FAIL %s: observed an=%b seg=%h idx=%0d ft=%b, expected an=%b seg=%h idx=%0d ft=%b",
                   tag, obs.an, obs.seg, obs.idx, obs.ft, e.an, e.seg, e.idx, e.ft);
        end
    endtask

    // Model: position in frame m_t decides slot and blank/lit phase directly.
    task automatic tick(input string tag);
        exp_t       e;
        int         pos;
        logic [1:0] s;
        if (!enable) begin
            m_run = 1'b0;
            m_t   = 0;
            e     = '{an: 4'hF, seg: 7'h7F, idx: 2'd0, ft: 1'b0};
        end else begin
            if (!m_run) begin
                m_run = 1'b1;
                m_t   = 0;
            end else begin
                m_t = (m_t + 1) % (4 * DIV);
            end
            if (m_t == 0) begin
                m_snap[0] = in0; m_snap[1] = in1; m_snap[2] = in2; m_snap[3] = in3;
                m_mask    = digit_en;
            end
            s      = 2'(m_t / DIV);
            pos    = m_t % DIV;
            e.an   = (pos < BLANK || !m_mask[s]) ? 4'hF : ~(4'b0001 << s);
            e.seg  = m_snap[s];
            e.idx  = s;
            e.ft   = (m_t == 0);
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check(tag, exp_q.pop_front());
        $display("%s t=%0t an=%b seg=%h idx=%0d ft=%b", tag, $time, an, seg, digit_idx, frame_tick);
        n_vec++;
        assert ($countones(~an) <= 1) else begin
            n_err++;
            $error("FAIL overlap_%s: observed an=%b, required at most one low bit", tag, an);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, required finish before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) m_snap[i] = 7'h7F;

        repeat (3) @(posedge clk);
        #1;
        check("reset", '{an: 4'hF, seg: 7'h7F, idx: 2'd0, ft: 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) tick("idle");

        digit_en = 4'hF;
        in0 = 7'h40; in1 = 7'h79; in2 = 7'h24; in3 = 7'h30;
        enable = 1'b1;
        repeat (32) tick("scan");
        repeat (12) tick("scan2");
        in2 = 7'h00;
        repeat (52) tick("coherency");

        digit_en = 4'b0101;
        repeat (70) tick("mask");

        for (int g = 0; g < 64 && m_t != 2 * DIV + 5; g++) tick("pre_drop");
        enable = 1'b0;
        tick("drop");
        repeat (3) tick("off");
        enable = 1'b1;
        tick("reenable");
        repeat (10) tick("resume");

        for (int g = 0; g < 64 && m_t != 3 * DIV + 4; g++) tick("pre_rst");
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst", '{an: 4'hF, seg: 7'h7F, idx: 2'd0, ft: 1'b0});
        m_run = 1'b0;
        for (int i = 0; i < 4; i++) m_snap[i] = 7'h7F;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) tick("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
